// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the block-copy DMA initiator: FSM state encoding and default widths.
package mem_copy_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned LEN_W_DEF  = 8;

endpackage

// File: rtl/mem_copy_dma.sv
// Block-copy bus initiator: reads LENGTH words from SRC, writes them to DST one word at a time,
// and accumulates a wrapping checksum of every word read.
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] data_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus outputs decode only from registered state and pointers, never from inputs.
    always_comb begin
        state_next     = state;
        busy           = 1'b1;
        done           = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (length != '0) ? RD : DONE;
                end
            end
            RD: begin
                mem_address = src_ptr;
                state_next  = WR;
            end
            WR: begin
                mem_write      = 1'b1;
                mem_address    = dst_ptr;
                mem_write_data = data_buf;
                state_next     = (count == LEN_W'(1)) ? DONE : RD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            data_buf <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr  <= src_addr;
                        dst_ptr  <= dst_addr;
                        count    <= length;
                        checksum <= '0;
                    end
                end
                RD: begin
                    data_buf <= mem_read_data;
                    checksum <= checksum + mem_read_data;
                end
                WR: begin
                    src_ptr <= src_ptr + ADDR_W'(1);
                    dst_ptr <= dst_ptr + ADDR_W'(1);
                    count   <= count - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: behavioural 256-word memory responder, table of copy vectors with a
// scoreboard of expected checksum/latency/write counts, plus hand-written reset-abort sequence.
module tb_mem_copy_dma;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic [15:0] checksum;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;

    mem_copy_dma #(
        .ADDR_W(16),
        .DATA_W(16),
        .LEN_W (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .checksum      (checksum),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: decodes address[7:0], combinational read, write at posedge.
    logic [15:0] ram [256];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_write) ram[mem_address[7:0]] <= mem_write_data;
    end
    assign mem_read_data = ram[mem_address[7:0]];

    logic [15:0] model_mem [256];

    typedef struct {
        string       name;
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  len;
        logic [15:0] exp_cks;
        bit          inject;
    } vec_t;

    typedef struct {
        logic [15:0] cks;
        int unsigned cycles;
        int unsigned writes;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    int checks   = 0;
    int failures = 0;

    localparam int unsigned BUDGET = 700;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        model_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic compare_mem(input string name);
        int unsigned bad = 0;
        for (int unsigned i = 0; i < 256; i++) begin
            if (ram[i] !== model_mem[i]) bad++;
        end
        check({name, "_mem"}, bad, 0);
    endtask

    task automatic run_xfer(input vec_t v);
        exp_t        e;
        exp_t        got_e;
        logic [15:0] w;
        int unsigned k;
        int unsigned writes;
        int unsigned rd_idx;
        int unsigned rd_bad;
        bit          got;

        for (int unsigned i = 0; i < v.len; i++) begin
            w = model_mem[8'(v.src + 16'(i))];
            model_mem[8'(v.dst + 16'(i))] = w;
        end
        e.cks    = v.exp_cks;
        e.cycles = 2 * int'(v.len) + 1;
        e.writes = int'(v.len);
        sb.push_back(e);

        @(negedge clk);
        start    = 1'b1;
        src_addr = v.src;
        dst_addr = v.dst;
        length   = v.len;
        @(negedge clk);
        start = 1'b0;
        check({v.name, "_busy1"}, busy, 1);

        k = 1; got = 0; writes = 0; rd_idx = 0; rd_bad = 0;
        while (!got && k <= BUDGET) begin
            if (done) begin
                got = 1;
            end else begin
                if (mem_write) begin
                    writes++;
                end else if (busy) begin
                    if (mem_address !== v.src + 16'(rd_idx)) rd_bad++;
                    rd_idx++;
                end
                if (v.inject && k == 2) begin
                    start    = 1'b1;
                    src_addr = 16'h0099;
                    dst_addr = 16'h0099;
                    length   = 8'd7;
                end
                if (v.inject && k == 3) start = 1'b0;
                @(negedge clk);
                k++;
            end
        end

        if (!got) begin
            check({v.name, "_timeout"}, 0, 1);
            void'(sb.pop_front());
        end else begin
            got_e = sb.pop_front();
            check({v.name, "_checksum"}, checksum, got_e.cks);
            check({v.name, "_done_cycle"}, k, got_e.cycles);
            check({v.name, "_writes"}, writes, got_e.writes);
            check({v.name, "_rd_addr"}, rd_bad, 0);
            @(negedge clk);
            check({v.name, "_done_pulse"}, done, 0);
            check({v.name, "_idle"}, busy, 0);
            check({v.name, "_cks_hold"}, checksum, got_e.cks);
            compare_mem(v.name);
        end
    endtask

    initial begin
        int unsigned k;
        int unsigned done_seen;

        rst_n    = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;

        vecs[0] = '{"copy2",    16'h0000, 16'h0020, 8'd2, 16'h2275, 1'b0};
        vecs[1] = '{"len0",     16'h0010, 16'h0030, 8'd0, 16'h0000, 1'b0};
        vecs[2] = '{"selfcopy", 16'h0009, 16'h0009, 8'd6, 16'h02B2, 1'b0};
        vecs[3] = '{"overlap",  16'h0040, 16'h0041, 8'd2, 16'h2222, 1'b0};
        vecs[4] = '{"wrap",     16'hFFFF, 16'h0050, 8'd2, 16'hC142, 1'b0};
        vecs[5] = '{"busystart",16'h0060, 16'h0070, 8'd4, 16'h0A0A, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_checksum", checksum, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 256; i++) preload(8'(i), 16'((i * 37) ^ 16'h5A5A));
        preload(8'h00, 16'h0253);
        preload(8'h01, 16'h2022);
        for (int unsigned i = 9; i <= 14; i++) preload(8'(i), 16'(i * 10));
        preload(8'h40, 16'h1111);
        preload(8'h41, 16'h2222);
        preload(8'hFF, 16'hBEEF);
        preload(8'h60, 16'h0101);
        preload(8'h61, 16'h0202);
        preload(8'h62, 16'h0303);
        preload(8'h63, 16'h0404);

        for (int unsigned i = 0; i < 6; i++) run_xfer(vecs[i]);

        // Abort mid-transfer during the first write cycle.
        preload(8'h80, 16'hAAAA);
        preload(8'h90, 16'h5555);
        @(negedge clk);
        start    = 1'b1;
        src_addr = 16'h0080;
        dst_addr = 16'h0090;
        length   = 8'd3;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!mem_write && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached_wr", mem_write, 1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_write", mem_write, 0);
        check("abort_busy", busy, 0);
        check("abort_mem_address", mem_address, 0);
        check("abort_checksum", checksum, 0);
        done_seen = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_no_partial_write", ram[8'h90], 16'h5555);
        compare_mem("abort");

        run_xfer(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
